// File: rtl/dram_arbiter_pkg.sv
// Shared types and defaults for the DRAM arbiter: the sequencer state
// encoding, interface width defaults and the address range helper.
package dram_arb_pkg;

  localparam int NUM_CORES_DEF = 4;
  localparam int ADDR_W_DEF    = 16;
  localparam int DATA_W_DEF    = 16;
  localparam int MEM_WORDS_DEF = 1025;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    DONE
  } arb_state_e;

  function automatic int grant_w(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

  localparam int GRANT_W_DEF = grant_w(NUM_CORES_DEF);

  function automatic logic addr_ok(input logic [31:0] addr, input int words);
    return addr < 32'(words);
  endfunction

endpackage

// File: rtl/dram_arbiter_rr_arbiter.sv
// Combinational round-robin pick: the first requester strictly after
// last_grant, wrapping, so the most recently served core ranks last.
module rr_arbiter
  import dram_arb_pkg::*;
#(
  parameter int N  = NUM_CORES_DEF,
  parameter int GW = grant_w(N)
) (
  input  logic [N-1:0]  req,
  input  logic [GW-1:0] last_grant,
  output logic [GW-1:0] grant,
  output logic          valid
);

  int idx;

  always_comb begin
    grant = '0;
    valid = 1'b0;
    idx   = 0;
    for (int i = 1; i <= N; i++) begin
      idx = (int'(last_grant) + i) % N;
      if (!valid && req[idx]) begin
        grant = GW'(idx);
        valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/dram_arbiter.sv
// Round-robin sequencer sharing one single-port DRAM among NUM_CORES cores,
// with a one-cycle registered read latency and per-core ack/err return.
module dram_arbiter
  import dram_arb_pkg::*;
#(
  parameter int NUM_CORES = NUM_CORES_DEF,
  parameter int ADDR_W    = ADDR_W_DEF,
  parameter int DATA_W    = DATA_W_DEF,
  parameter int MEM_WORDS = MEM_WORDS_DEF,
  localparam int GRANT_W  = grant_w(NUM_CORES)
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [NUM_CORES-1:0]        core_req,
  input  logic [NUM_CORES-1:0]        core_we,
  input  logic [NUM_CORES*ADDR_W-1:0] core_addr,
  input  logic [NUM_CORES*DATA_W-1:0] core_wdata,
  output logic [NUM_CORES-1:0]        core_ack,
  output logic [DATA_W-1:0]           core_rdata,
  output logic                        core_err,
  output logic                        busy,
  output logic [GRANT_W-1:0]          grant_id,
  output logic                        mem_we,
  output logic [ADDR_W-1:0]           mem_addr,
  output logic [DATA_W-1:0]           mem_wdata,
  input  logic [DATA_W-1:0]           mem_rdata
);

  arb_state_e state_q, state_d;

  logic [GRANT_W-1:0]   grant_id_q, grant_id_d;
  logic [GRANT_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic                 lat_we_q, lat_we_d;
  logic                 lat_ok_q, lat_ok_d;
  logic [ADDR_W-1:0]    mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0]    mem_wdata_q, mem_wdata_d;
  logic                 mem_we_q, mem_we_d;
  logic [DATA_W-1:0]    core_rdata_q, core_rdata_d;
  logic [NUM_CORES-1:0] core_ack_q, core_ack_d;
  logic                 core_err_q, core_err_d;

  logic [GRANT_W-1:0] arb_grant;
  logic               arb_valid;
  logic               sel_we;
  logic [ADDR_W-1:0]  sel_addr;
  logic [DATA_W-1:0]  sel_wdata;
  logic               sel_ok;

  rr_arbiter #(
    .N  (NUM_CORES),
    .GW (GRANT_W)
  ) u_rr (
    .req        (core_req),
    .last_grant (rr_ptr_q),
    .grant      (arb_grant),
    .valid      (arb_valid)
  );

  assign sel_we    = core_we[arb_grant];
  assign sel_addr  = core_addr[int'(arb_grant)*ADDR_W +: ADDR_W];
  assign sel_wdata = core_wdata[int'(arb_grant)*DATA_W +: DATA_W];
  assign sel_ok    = addr_ok(32'(sel_addr), MEM_WORDS);

  // Arbitration is held off during the ack cycle: the acked core may still
  // be holding req, and only from the following cycle is it a new request.
  always_comb begin
    state_d      = state_q;
    grant_id_d   = grant_id_q;
    rr_ptr_d     = rr_ptr_q;
    lat_we_d     = lat_we_q;
    lat_ok_d     = lat_ok_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    core_rdata_d = core_rdata_q;
    mem_we_d     = 1'b0;
    core_ack_d   = '0;
    core_err_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (arb_valid && (core_ack_q == '0)) begin
          grant_id_d  = arb_grant;
          lat_we_d    = sel_we;
          lat_ok_d    = sel_ok;
          mem_addr_d  = sel_addr;
          mem_wdata_d = sel_wdata;
          mem_we_d    = sel_we & sel_ok;
          state_d     = ISSUE;
        end
      end
      ISSUE: state_d = lat_we_q ? DONE : WAIT;
      WAIT: begin
        core_rdata_d = lat_ok_q ? mem_rdata : '0;
        state_d      = DONE;
      end
      DONE: begin
        core_ack_d[grant_id_q] = 1'b1;
        core_err_d             = ~lat_ok_q;
        rr_ptr_d               = grant_id_q;
        state_d                = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Pointer resets to the last core so that core 0 wins the first pick.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      grant_id_q   <= '0;
      rr_ptr_q     <= GRANT_W'(NUM_CORES - 1);
      lat_we_q     <= 1'b0;
      lat_ok_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      mem_we_q     <= 1'b0;
      core_rdata_q <= '0;
      core_ack_q   <= '0;
      core_err_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      grant_id_q   <= grant_id_d;
      rr_ptr_q     <= rr_ptr_d;
      lat_we_q     <= lat_we_d;
      lat_ok_q     <= lat_ok_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      mem_we_q     <= mem_we_d;
      core_rdata_q <= core_rdata_d;
      core_ack_q   <= core_ack_d;
      core_err_q   <= core_err_d;
    end
  end

  assign core_ack   = core_ack_q;
  assign core_err   = core_err_q;
  assign core_rdata = core_rdata_q;
  assign grant_id   = grant_id_q;
  assign busy       = (state_q != IDLE);
  assign mem_we     = mem_we_q;
  assign mem_addr   = mem_addr_q;
  assign mem_wdata  = mem_wdata_q;

endmodule

// File: tb/tb_dram_arbiter.sv
// Self-checking bench for dram_arbiter: directed scenarios with literal
// expectations, then randomized traffic against a transaction-level model.
module tb_dram_arbiter;

  localparam int NC    = 4;
  localparam int WORDS = 1025;

  logic          clk;
  logic          rst_n;
  logic [NC-1:0] core_req;
  logic [NC-1:0] core_we;
  logic [63:0]   core_addr;
  logic [63:0]   core_wdata;
  logic [NC-1:0] core_ack;
  logic [15:0]   core_rdata;
  logic          core_err;
  logic          busy;
  logic [1:0]    grant_id;
  logic          mem_we;
  logic [15:0]   mem_addr;
  logic [15:0]   mem_wdata;
  logic [15:0]   mem_rdata;

  int n_checks = 0;
  int n_fails  = 0;

  dram_arbiter #(
    .NUM_CORES (NC),
    .ADDR_W    (16),
    .DATA_W    (16),
    .MEM_WORDS (WORDS)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .core_req   (core_req),
    .core_we    (core_we),
    .core_addr  (core_addr),
    .core_wdata (core_wdata),
    .core_ack   (core_ack),
    .core_rdata (core_rdata),
    .core_err   (core_err),
    .busy       (busy),
    .grant_id   (grant_id),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [15:0] init_word(input int a);
    if (a == 10) return 16'd85;
    return 16'((a * 37 + 11) ^ 16'h5A5A);
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fails++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  // DRAM environment: registered read, write on mem_we, contents seeded on first edge.
  logic [15:0] dram [0:WORDS-1];
  bit          dram_ready = 1'b0;
  logic [15:0] dram_rd;

  always @(posedge clk) begin
    if (!dram_ready) begin
      for (int i = 0; i < WORDS; i++) dram[i] = init_word(i);
      dram_ready = 1'b1;
    end
    dram_rd = (int'(mem_addr) < WORDS) ? dram[int'(mem_addr)] : 16'h0;
    if (mem_we && int'(mem_addr) < WORDS) dram[int'(mem_addr)] = mem_wdata;
    mem_rdata <= dram_rd;
  end

  // Transaction-level reference: one transaction at a time, ack 3 (write)
  // or 4 (read) cycles after the arbitration cycle, no pick in the ack cycle.
  logic [15:0] ref_mem [0:WORDS-1];
  bit          ref_ready = 1'b0;
  bit          model_on  = 1'b0;
  int          cyc = 0;
  bit          in_flight;
  int          arb_cyc, ack_at, cur_core, last_g;
  bit          cur_we, cur_ok, ack_now;
  logic [15:0] cur_rd, rdata_exp, addr_exp, wdata_exp;
  logic [1:0]  grant_exp;
  logic [3:0]  exp_ack;

  always @(negedge clk) begin
    if (!ref_ready) begin
      for (int i = 0; i < WORDS; i++) ref_mem[i] = init_word(i);
      ref_ready = 1'b1;
    end
    cyc++;
    ack_now = 1'b0;
    if (model_on) begin
      ack_now = in_flight && (cyc == ack_at);
      exp_ack = ack_now ? (4'b0001 << cur_core) : 4'b0000;
      if (ack_now && !cur_we) rdata_exp = cur_rd;
      checkOutput("m_ack", 32'(core_ack), 32'(exp_ack));
      checkOutput("m_err", 32'(core_err), 32'(ack_now && !cur_ok));
      checkOutput("m_busy", 32'(busy), 32'(in_flight && cyc < ack_at));
      checkOutput("m_mem_we", 32'(mem_we), 32'(in_flight && cyc == arb_cyc + 1 && cur_we && cur_ok));
      checkOutput("m_grant_id", 32'(grant_id), 32'(grant_exp));
      checkOutput("m_mem_addr", 32'(mem_addr), 32'(addr_exp));
      checkOutput("m_mem_wdata", 32'(mem_wdata), 32'(wdata_exp));
      if (!(in_flight && !cur_we && cyc == ack_at - 1))
        checkOutput("m_rdata", 32'(core_rdata), 32'(rdata_exp));
      if (ack_now) begin
        in_flight = 1'b0;
        last_g    = cur_core;
      end
    end
    if (!rst_n) begin
      model_on  = 1'b1;
      in_flight = 1'b0;
      last_g    = NC - 1;
      rdata_exp = '0;
      addr_exp  = '0;
      wdata_exp = '0;
      grant_exp = '0;
    end else if (model_on && !in_flight && !ack_now && core_req != '0) begin
      cur_core = -1;
      for (int k = 1; k <= NC; k++)
        if (cur_core < 0 && core_req[(last_g + k) % NC]) cur_core = (last_g + k) % NC;
      cur_we    = core_we[cur_core];
      addr_exp  = core_addr[cur_core*16 +: 16];
      wdata_exp = core_wdata[cur_core*16 +: 16];
      cur_ok    = int'(addr_exp) < WORDS;
      cur_rd    = cur_ok ? ref_mem[int'(addr_exp)] : 16'h0;
      if (cur_we && cur_ok) ref_mem[int'(addr_exp)] = wdata_exp;
      grant_exp = 2'(cur_core);
      arb_cyc   = cyc;
      ack_at    = cyc + (cur_we ? 3 : 4);
      in_flight = 1'b1;
    end
  end

  // Core-side agents: inputs change at posedge+1, req drops the cycle after ack.
  logic [NC-1:0] acked_last   = '0;
  logic [NC-1:0] hold         = '0;
  logic [NC-1:0] just_dropped = '0;
  bit            rand_mode    = 1'b0;
  int            ack_order [0:15];
  int            ack_cnt;
  int            lat, we_cnt;
  logic [15:0]   we_addr;

  function automatic logic [15:0] randAddr();
    int r;
    r = $urandom_range(0, 9);
    if (r <= 6) return 16'($urandom_range(0, 15));
    if (r == 7) return 16'd1024;
    if (r == 8) return 16'(1025 + $urandom_range(0, 3));
    return 16'($urandom);
  endfunction

  task automatic applyStimulus(input int core, input bit we, input logic [15:0] addr,
                               input logic [15:0] wdata);
    core_we[core]             = we;
    core_addr[core*16 +: 16]  = addr;
    core_wdata[core*16 +: 16] = wdata;
    core_req[core]            = 1'b1;
  endtask

  task automatic randomParams(input int core);
    applyStimulus(core, 1'($urandom_range(0, 1)), randAddr(), 16'($urandom));
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    just_dropped = '0;
    for (int i = 0; i < NC; i++) begin
      if (acked_last[i]) begin
        if (hold[i]) begin
          if (rand_mode) randomParams(i);
        end else begin
          core_req[i]     = 1'b0;
          just_dropped[i] = 1'b1;
        end
      end
    end
    acked_last = core_ack;
  endtask

  task automatic waitAck(input int core, input int limit);
    lat    = 0;
    we_cnt = 0;
    do begin
      tick();
      lat++;
      if (mem_we) begin
        we_cnt++;
        we_addr = mem_addr;
      end
    end while (!core_ack[core] && lat < limit);
    checkOutput("ack_seen", 32'(core_ack[core]), 32'd1);
  endtask

  task automatic collectAcks(input int n, input int limit);
    int t;
    t       = 0;
    ack_cnt = 0;
    while (ack_cnt < n && t < limit) begin
      tick();
      t++;
      if (core_ack != '0) begin
        for (int i = 0; i < NC; i++) if (core_ack[i]) ack_order[ack_cnt] = i;
        ack_cnt++;
      end
    end
    checkOutput("ack_count", 32'(ack_cnt), 32'(n));
  endtask

  task automatic waitQuiet(input int limit);
    int t;
    t = 0;
    while ((core_req != '0 || busy || core_ack != '0) && t < limit) begin
      tick();
      t++;
    end
    checkOutput("quiet_req", 32'(core_req), 32'd0);
    checkOutput("quiet_busy", 32'(busy), 32'd0);
  endtask

  task automatic pulseReset();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst_n      = 1'b0;
    core_req   = '0;
    core_we    = '0;
    core_addr  = '0;
    core_wdata = '0;
    repeat (3) tick();
    checkOutput("rst_ack", 32'(core_ack), 32'd0);
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_mem_we", 32'(mem_we), 32'd0);
    checkOutput("rst_grant", 32'(grant_id), 32'd0);
    checkOutput("rst_rdata", 32'(core_rdata), 32'd0);
    checkOutput("rst_addr", 32'(mem_addr), 32'd0);
    rst_n = 1'b1;
    tick();

    $display("[TB] single read");
    applyStimulus(1, 1'b0, 16'd10, 16'h0);
    waitAck(1, 10);
    checkOutput("rd_latency", 32'(lat), 32'd4);
    checkOutput("rd_ack", 32'(core_ack), 32'b0010);
    checkOutput("rd_data", 32'(core_rdata), 32'd85);
    checkOutput("rd_err", 32'(core_err), 32'd0);
    checkOutput("rd_no_we", 32'(we_cnt), 32'd0);
    tick();

    $display("[TB] write then read");
    applyStimulus(0, 1'b1, 16'd5, 16'h1234);
    waitAck(0, 10);
    checkOutput("wr_latency", 32'(lat), 32'd3);
    checkOutput("wr_we_cycles", 32'(we_cnt), 32'd1);
    checkOutput("wr_we_addr", 32'(we_addr), 32'd5);
    checkOutput("wr_err", 32'(core_err), 32'd0);
    tick();
    applyStimulus(0, 1'b0, 16'd5, 16'h0);
    waitAck(0, 10);
    checkOutput("rbw_latency", 32'(lat), 32'd4);
    checkOutput("rbw_data", 32'(core_rdata), 32'h1234);
    tick();

    $display("[TB] contention");
    pulseReset();
    applyStimulus(0, 1'b0, 16'd1, 16'h0);
    applyStimulus(2, 1'b1, 16'd2, 16'hA5A5);
    applyStimulus(3, 1'b0, 16'd2, 16'h0);
    collectAcks(3, 40);
    checkOutput("cont_first", 32'(ack_order[0]), 32'd0);
    checkOutput("cont_second", 32'(ack_order[1]), 32'd2);
    checkOutput("cont_third", 32'(ack_order[2]), 32'd3);
    checkOutput("cont_rdata", 32'(core_rdata), 32'hA5A5);
    tick();
    applyStimulus(0, 1'b1, 16'd3, 16'h0F0F);
    applyStimulus(3, 1'b1, 16'd4, 16'hF0F0);
    collectAcks(2, 30);
    checkOutput("wrap_first", 32'(ack_order[0]), 32'd0);
    checkOutput("wrap_second", 32'(ack_order[1]), 32'd3);
    tick();

    $display("[TB] fairness");
    pulseReset();
    hold = 4'hF;
    for (int i = 0; i < NC; i++) applyStimulus(i, 1'(i % 2), 16'(8 + i), 16'(i * 3));
    collectAcks(8, 80);
    for (int i = 0; i < 8; i++) checkOutput("fair_order", 32'(ack_order[i]), 32'(i % NC));
    hold = '0;
    waitQuiet(60);

    $display("[TB] out of range");
    tick();
    applyStimulus(2, 1'b1, 16'd1025, 16'hFFFF);
    waitAck(2, 10);
    checkOutput("oor_wr_we", 32'(we_cnt), 32'd0);
    checkOutput("oor_wr_err", 32'(core_err), 32'd1);
    tick();
    applyStimulus(1, 1'b0, 16'd10, 16'h0);
    waitAck(1, 10);
    checkOutput("pre_oor_data", 32'(core_rdata), 32'd85);
    tick();
    applyStimulus(2, 1'b0, 16'd2000, 16'h0);
    waitAck(2, 10);
    checkOutput("oor_rd_data", 32'(core_rdata), 32'd0);
    checkOutput("oor_rd_err", 32'(core_err), 32'd1);
    tick();
    applyStimulus(3, 1'b0, 16'd1024, 16'h0);
    waitAck(3, 10);
    checkOutput("edge_rd_data", 32'(core_rdata), 32'(init_word(1024)));
    checkOutput("edge_rd_err", 32'(core_err), 32'd0);
    tick();

    $display("[TB] reset mid-op");
    applyStimulus(0, 1'b1, 16'd7, 16'hBEEF);
    waitAck(0, 10);
    tick();
    applyStimulus(1, 1'b0, 16'd7, 16'h0);
    tick();
    tick();
    checkOutput("mid_busy_wait", 32'(busy), 32'd1);
    rst_n       = 1'b0;
    core_req[1] = 1'b0;
    tick();
    checkOutput("mid_rst_ack", 32'(core_ack), 32'd0);
    checkOutput("mid_rst_busy", 32'(busy), 32'd0);
    checkOutput("mid_rst_we", 32'(mem_we), 32'd0);
    tick();
    rst_n = 1'b1;
    ack_cnt = 0;
    repeat (4) begin
      tick();
      if (core_ack != '0) ack_cnt++;
    end
    checkOutput("mid_no_ack", 32'(ack_cnt), 32'd0);
    applyStimulus(0, 1'b0, 16'd7, 16'h0);
    applyStimulus(3, 1'b0, 16'd5, 16'h0);
    collectAcks(2, 30);
    checkOutput("post_rst_first", 32'(ack_order[0]), 32'd0);
    checkOutput("post_rst_second", 32'(ack_order[1]), 32'd3);
    checkOutput("post_rst_rdata", 32'(core_rdata), 32'h1234);
    tick();

    $display("[TB] random traffic");
    rand_mode = 1'b1;
    for (int c = 0; c < 1500; c++) begin
      tick();
      if (c == 750) begin
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
      end
      if (!busy) begin
        for (int i = 0; i < NC; i++) begin
          if (!core_req[i] && !just_dropped[i] && $urandom_range(0, 3) == 0) begin
            randomParams(i);
            hold[i] = ($urandom_range(0, 3) == 0);
          end
        end
      end
    end
    hold      = '0;
    rand_mode = 1'b0;
    waitQuiet(100);
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule

// File: doc/dram_arbiter.md
Name: dram_arbiter

Overview:
- Round-robin arbiter and sequencer that lets NUM_CORES processor cores share the single-port DRAM block.
- Accepts per-core req/ack transactions, serialises them onto the DRAM's write_en/addr/data_in/data_out interface, honours its one-cycle registered read latency, and returns read data and completion to the winning core.
- Sits between the core load/store units and the DRAM instance.

Parameters:
- NUM_CORES, 4, number of requesting cores (2..8).
- ADDR_W, 16, address width, matches the DRAM addr port.
- DATA_W, 16, data width, matches the DRAM data ports.
- MEM_WORDS, 1025, valid DRAM word count; legal addresses are 0..MEM_WORDS-1.

Ports:
- clk  in  1  system clock; all logic is on the rising edge.
- rst_n  in  1  synchronous, active-low reset.
- core_req  in  NUM_CORES  per-core request; held high until the matching core_ack.
- core_we  in  NUM_CORES  per-core op: 1 = write, 0 = read.
- core_addr  in  NUM_CORES*ADDR_W  per-core address; core i occupies slice [i*ADDR_W +: ADDR_W].
- core_wdata  in  NUM_CORES*DATA_W  per-core write data, same slicing.
- core_ack  out  NUM_CORES  one-hot, one-cycle completion pulse.
- core_rdata  out  DATA_W  shared read-data return; valid when core_ack is high for a read.
- core_err  out  1  high with core_ack when the address was out of range.
- busy  out  1  high in every state except IDLE.
- grant_id  out  $clog2(NUM_CORES)  index of the core being served; holds its last value in IDLE.
- mem_we  out  1  to DRAM write_en.
- mem_addr  out  ADDR_W  to DRAM addr.
- mem_wdata  out  DATA_W  to DRAM data_in.
- mem_rdata  in  DATA_W  from DRAM data_out.

Behaviour:
- Reset (rst_n low at a rising edge)
  - state=IDLE; core_ack=0, core_err=0, mem_we=0.
  - mem_addr=0, mem_wdata=0, core_rdata=0, grant_id=0.
  - Round-robin pointer set so core 0 has highest priority.
  - Reset asserted mid-transaction aborts it: no ack is issued and mem_we is low from the next cycle. A write already sampled by the DRAM is not undone.
- FSM states: IDLE, ISSUE, WAIT, DONE. All outputs are registered or decoded from registered state.
- IDLE
  - If any core_req is high, the round-robin pick selects the first requester after the last granted index, wrapping.
  - Latch that core's we/addr/wdata into mem_* holding registers, set grant_id, and go to ISSUE.
  - If no request is pending, stay in IDLE.
- ISSUE
  - mem_addr/mem_wdata come from the latched values; mem_we equals the latched we AND address-in-range.
  - The DRAM samples at the end of this cycle.
  - Write: go to DONE. Read: go to WAIT.
- WAIT (reads only)
  - mem_we=0 and mem_addr is held.
  - mem_rdata is valid this cycle; capture it into core_rdata at the end of the cycle, or capture 0 if the address is out of range.
  - Go to DONE.
- DONE
  - core_ack[grant_id]=1 for exactly one cycle; core_err=1 if addr >= MEM_WORDS.
  - Update the round-robin pointer to grant_id; go to IDLE.
- Latency from req sampled in IDLE to ack: write 3 cycles, read 4 cycles. Maximum throughput is one transaction per 4 (write) or 5 (read) cycles, including the IDLE arbitration cycle.
- core_rdata holds its value until the next read completes; writes do not change it.
- Out-of-range address: the DRAM is never written (mem_we stays 0), a read returns 0, and core_err pulses with ack.
- A requester must drop core_req in the cycle after ack. A still-high req is treated as a new request and gets lowest priority, which guarantees fairness.
- Request inputs change only in IDLE-sampled cycles. Changes to a granted core's inputs after latching are ignored.
- Simultaneous requests from all cores are served in strict rotation. Worst-case wait is NUM_CORES-1 transactions.

Decomposition:
- Package dram_arb_pkg holds:
  - the state enum (IDLE, ISSUE, WAIT, DONE);
  - ADDR_W/DATA_W defaults, MEM_WORDS, and the GRANT_W = $clog2(NUM_CORES) helper.
- Sub-module rr_arbiter (parameter N):
  - inputs: req vector, last-grant index;
  - outputs: grant index and a valid flag;
  - purely combinational priority rotation.
- dram_arbiter itself holds the FSM, latch registers and DRAM interface.

Test Plan:
- Single read: DRAM[10]=85 preloaded; core 1 reads addr 10 -> mem_we stays 0; core_ack=4'b0010 exactly 4 cycles after req; core_rdata=85; core_err=0.
- Write then read: core 0 writes 0x1234 to addr 5 -> mem_we=1 for one cycle with addr 5; ack 3 cycles after req; a following read of addr 5 returns 0x1234.
- Contention: cores 0, 2 and 3 raise req in the same cycle, each dropping it after its ack -> acks in order 0, 2, 3. Then core 0 and core 3 re-request together -> core 0 is served first (pointer after 3 wraps to 0).
- Fairness: all 4 cores hold req continuously for 8 transactions -> grant_id sequence 0,1,2,3,0,1,2,3 and no core starves.
- Out of range: core 2 writes 0xFFFF to addr 1025 -> mem_we never high; ack with core_err=1. A read of addr 2000 returns core_rdata=0 with core_err=1.
- Reset mid-op: assert rst_n low during WAIT of a read -> no core_ack; busy=0, mem_we=0 next cycle. After release, a core 3 request is served, with core 0 priority restored.
